hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage pipelined CPU. It produces the write-enable and flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM stage registers. It detects three conditions: load-use hazards (ID vs. EX), taken branches resolved in EX, and data-memory busy. Its state machine holds multi-cycle stalls and flushes so that each pipeline register only sees a plain enable/flush pair.

## Interface
Parameters:
- FLUSH_DEPTH, 1: total cycles IF/ID is flushed per taken branch, counting the detection cycle; legal range 1..4.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- RnId  in  5  ID-stage first source register.
- RmId  in  5  ID-stage second source register.
- usesRn  in  1  ID instruction reads Rn.
- usesRm  in  1  ID instruction reads Rm.
- RdEx  in  5  EX-stage destination register (ID/EX RdOut).
- regWriteEx  in  1  EX instruction writes the register file.
- memToRegEx  in  2  EX writeback select; 2'b01 means load.
- brTakenEx  in  1  branch in EX resolved taken.
- dmemBusy  in  1  data memory cannot complete this cycle.
- pcWrite  out  1  PC register enable.
- ifidWrite  out  1  IF/ID enable.
- ifidFlush  out  1  IF/ID loads a bubble.
- idexWrite  out  1  ID/EX enable.
- idexFlush  out  1  ID/EX loads a bubble (all control zero).
- exmemWrite  out  1  EX/MEM enable.
- stallCount  out  CNT_W  load-use stall cycles, saturating.
- flushCount  out  CNT_W  taken branches, saturating.

## Operation
- States: RUN, LDSTALL, BRFLUSH, MEMWAIT. A down-counter flushCnt (2 bits) is used by BRFLUSH.
- loadUse = regWriteEx & (memToRegEx==2'b01) & (RdEx!=5'd31) & ((usesRn & RnId==RdEx) | (usesRm & RmId==RdEx)).
- Outputs are Mealy: decoded from the current state and the current inputs. Defaults: all write enables = 1, all flushes = 0.
- Priority, highest first: dmemBusy, brTakenEx, BRFLUSH, loadUse.
- dmemBusy = 1 (any state):
  - pcWrite = ifidWrite = idexWrite = exmemWrite = 0; no flush.
  - Next state is MEMWAIT. The interrupted state and flushCnt are saved and resumed when busy drops.
- brTakenEx = 1 with dmemBusy = 0:
  - ifidFlush = idexFlush = 1; pcWrite = 1 (target loads).
  - If FLUSH_DEPTH > 1: next state BRFLUSH with flushCnt = FLUSH_DEPTH-2. Otherwise next state RUN.
  - flushCount increments.
- BRFLUSH:
  - ifidFlush = 1; loadUse is ignored.
  - flushCnt decrements; at flushCnt = 0 the next state is RUN.
  - A new brTakenEx during BRFLUSH restarts the sequence.
- RUN with loadUse:
  - pcWrite = ifidWrite = 0; idexFlush = 1.
  - Next state LDSTALL; stallCount increments.
- LDSTALL: default outputs, loadUse suppressed for one cycle, next state RUN.
- MEMWAIT with dmemBusy = 0: resume the saved state; that cycle is evaluated as that state.
- RdEx = 31 (XZR) never causes a stall.

## Timing
- Detection-to-control latency is 0 cycles; outputs settle in the same cycle as their inputs.
- Load-use costs exactly one bubble. A taken branch costs FLUSH_DEPTH bubbles in IF/ID plus one in ID/EX.
- Reset (reset = 0 at a posedge, including mid-stall or mid-flush):
  - State = RUN, flushCnt = 0, saved state = RUN, counters = 0.
  - While reset is held low, outputs are the defaults (all enables 1, flushes 0).
- Counters saturate at all-ones; no wrap-around.

## Configuration
- HAZARD_STATS_EN defined: stallCount and flushCount are implemented as described.
- HAZARD_STATS_EN undefined: no counter registers are built. Both ports remain in the interface, tied to 0.

## Test plan
- Reset then loadUse (RdEx=3, RnId=3, usesRn=1, memToRegEx=01, regWriteEx=1) -> cycle 0: pcWrite=0, ifidWrite=0, idexFlush=1. Cycle 1: defaults despite unchanged inputs. stallCount=1.
- RdEx=31 with a matching RnId and a load in EX -> no stall, outputs at default.
- FLUSH_DEPTH=3, brTakenEx one cycle -> ifidFlush=1 for 3 cycles, idexFlush=1 for the first cycle only, flushCount=1.
- dmemBusy high for 4 cycles in the middle of BRFLUSH (FLUSH_DEPTH=3) -> all enables 0 for the 4 cycles. After busy drops, the remaining flush cycles complete with total ifidFlush cycles = 3.
- brTakenEx and loadUse in the same cycle -> branch wins: both flushes = 1, pcWrite = 1, stallCount unchanged.
- reset pulled low during LDSTALL -> next cycle state RUN, counters 0, outputs at default.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Bundle between the pipeline datapath and the hazard controller.
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       RnId;
    logic [4:0]       RmId;
    logic             usesRn;
    logic             usesRm;
    logic [4:0]       RdEx;
    logic             regWriteEx;
    logic [1:0]       memToRegEx;
    logic             brTakenEx;
    logic             dmemBusy;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexWrite;
    logic             idexFlush;
    logic             exmemWrite;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    // Pipeline side: supplies hazard sources, consumes stage controls.
    modport master (
        output RnId, RmId, usesRn, usesRm, RdEx, regWriteEx, memToRegEx,
               brTakenEx, dmemBusy,
        input  pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush,
               exmemWrite, stallCount, flushCount
    );

    modport slave (
        input  RnId, RmId, usesRn, usesRm, RdEx, regWriteEx, memToRegEx,
               brTakenEx, dmemBusy,
        output pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush,
               exmemWrite, stallCount, flushCount
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use / taken-branch / dmem-busy hazard controller for the
//            five-stage pipeline. Statistics counters built only when
//            HAZARD_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  wire logic     clk,
    input  wire logic     reset,
    hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_LDSTALL = 2'd1;
    localparam logic [1:0] c_BRFLUSH = 2'd2;
    localparam logic [1:0] c_MEMWAIT = 2'd3;

    localparam logic [1:0] c_FLUSH_INIT = (FLUSH_DEPTH > 1) ? 2'(FLUSH_DEPTH - 2) : 2'd0;

    logic [1:0] r_state;
    logic [1:0] r_savedState;
    logic [1:0] r_flushCnt;
    logic [1:0] w_nextState;
    logic [1:0] w_nextSaved;
    logic [1:0] w_nextCnt;
    logic [1:0] w_effState;
    logic       w_loadUse;

    logic       w_pcWrite;
    logic       w_ifidWrite;
    logic       w_ifidFlush;
    logic       w_idexWrite;
    logic       w_idexFlush;
    logic       w_exmemWrite;

    // On the cycle busy drops, MEMWAIT behaves exactly like the interrupted state.
    assign w_effState = (r_state == c_MEMWAIT) ? r_savedState : r_state;

    assign w_loadUse = hz.regWriteEx && (hz.memToRegEx == 2'b01) && (hz.RdEx != 5'd31) &&
                       ((hz.usesRn && (hz.RnId == hz.RdEx)) ||
                        (hz.usesRm && (hz.RmId == hz.RdEx)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_RUN;
            r_savedState <= c_RUN;
            r_flushCnt   <= 2'd0;
        end else begin
            r_state      <= w_nextState;
            r_savedState <= w_nextSaved;
            r_flushCnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextSaved = r_savedState;
        w_nextCnt   = r_flushCnt;
        if (hz.dmemBusy) begin
            // flushCnt is simply held, which preserves it across the wait.
            w_nextState = c_MEMWAIT;
            w_nextSaved = w_effState;
        end else if (hz.brTakenEx) begin
            if (FLUSH_DEPTH > 1) begin
                w_nextState = c_BRFLUSH;
                w_nextCnt   = c_FLUSH_INIT;
            end else begin
                w_nextState = c_RUN;
            end
        end else begin
            case (w_effState)
                c_BRFLUSH: begin
                    if (r_flushCnt == 2'd0) begin
                        w_nextState = c_RUN;
                    end else begin
                        w_nextState = c_BRFLUSH;
                        w_nextCnt   = r_flushCnt - 2'd1;
                    end
                end
                c_RUN: begin
                    w_nextState = w_loadUse ? c_LDSTALL : c_RUN;
                end
                default: begin
                    w_nextState = c_RUN;
                end
            endcase
        end
    end

    always_comb begin
        w_pcWrite    = 1'b1;
        w_ifidWrite  = 1'b1;
        w_ifidFlush  = 1'b0;
        w_idexWrite  = 1'b1;
        w_idexFlush  = 1'b0;
        w_exmemWrite = 1'b1;
        if (reset) begin
            if (hz.dmemBusy) begin
                w_pcWrite    = 1'b0;
                w_ifidWrite  = 1'b0;
                w_idexWrite  = 1'b0;
                w_exmemWrite = 1'b0;
            end else if (hz.brTakenEx) begin
                w_ifidFlush = 1'b1;
                w_idexFlush = 1'b1;
            end else begin
                case (w_effState)
                    c_BRFLUSH: w_ifidFlush = 1'b1;
                    c_RUN: begin
                        if (w_loadUse) begin
                            w_pcWrite   = 1'b0;
                            w_ifidWrite = 1'b0;
                            w_idexFlush = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign hz.pcWrite    = w_pcWrite;
    assign hz.ifidWrite  = w_ifidWrite;
    assign hz.ifidFlush  = w_ifidFlush;
    assign hz.idexWrite  = w_idexWrite;
    assign hz.idexFlush  = w_idexFlush;
    assign hz.exmemWrite = w_exmemWrite;

`ifdef HAZARD_STATS_EN
    logic             w_stallEvt;
    logic             w_flushEvt;
    logic [CNT_W-1:0] r_stallCount;
    logic [CNT_W-1:0] r_flushCount;

    assign w_stallEvt = !hz.dmemBusy && !hz.brTakenEx && (w_effState == c_RUN) && w_loadUse;
    assign w_flushEvt = !hz.dmemBusy && hz.brTakenEx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (w_stallEvt && (r_stallCount != {CNT_W{1'b1}})) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (w_flushEvt && (r_flushCount != {CNT_W{1'b1}})) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end
    end

    assign hz.stallCount = r_stallCount;
    assign hz.flushCount = r_flushCount;
`else
    assign hz.stallCount = {CNT_W{1'b0}};
    assign hz.flushCount = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed self-checking bench for hazard_ctrl (FLUSH_DEPTH = 3).
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_CNT_W = 16;

    // Output vector order: pcWrite ifidWrite ifidFlush idexWrite idexFlush exmemWrite
    localparam logic [5:0] c_DEF  = 6'b110101;
    localparam logic [5:0] c_LDU  = 6'b000111;
    localparam logic [5:0] c_BR   = 6'b111111;
    localparam logic [5:0] c_BRF  = 6'b111101;
    localparam logic [5:0] c_BUSY = 6'b000000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   statsOn;
    int   expStall;
    int   expFlush;

    hazard_ctrl_if #(.CNT_W(c_CNT_W)) hz ();

    hazard_ctrl #(
        .FLUSH_DEPTH (3),
        .CNT_W       (c_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {hz.pcWrite, hz.ifidWrite, hz.ifidFlush, hz.idexWrite, hz.idexFlush, hz.exmemWrite};
    endfunction

    task automatic setIdle();
        hz.RnId       = 5'd1;
        hz.RmId       = 5'd2;
        hz.usesRn     = 1'b0;
        hz.usesRm     = 1'b0;
        hz.RdEx       = 5'd9;
        hz.regWriteEx = 1'b0;
        hz.memToRegEx = 2'b00;
        hz.brTakenEx  = 1'b0;
        hz.dmemBusy   = 1'b0;
    endtask

    task automatic applyLoadRn(input logic [4:0] rd);
        hz.RdEx       = rd;
        hz.RnId       = rd;
        hz.usesRn     = 1'b1;
        hz.regWriteEx = 1'b1;
        hz.memToRegEx = 2'b01;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        setIdle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        applyLoadRn(5'd3);
        hz.brTakenEx = 1'b1;
        #1;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", outs(), c_DEF);
        end
        checks++;
        if (hz.stallCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_stallCount: got %0d want 0", hz.stallCount);
        end
        checks++;
        if (hz.flushCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_flushCount: got %0d want 0", hz.flushCount);
        end
        @(negedge clk);
        setIdle();
        reset = 1'b1;
    endtask

    task automatic test_loaduse();
        @(negedge clk);
        applyLoadRn(5'd3);
        #1;
        checks++;
        if (outs() !== c_LDU) begin
            errors++;
            $display("FAIL loaduse_rn: got %b want %b", outs(), c_LDU);
        end
        expStall = expStall + statsOn;
        @(negedge clk);
        #1;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL loaduse_ldstall: got %b want %b", outs(), c_DEF);
        end
        checks++;
        if (hz.stallCount !== 16'(expStall)) begin
            errors++;
            $display("FAIL loaduse_stallCount: got %0d want %0d", hz.stallCount, expStall);
        end
        // Second source operand match
        @(negedge clk);
        setIdle();
        hz.RdEx = 5'd7; hz.RmId = 5'd7; hz.usesRm = 1'b1;
        hz.regWriteEx = 1'b1; hz.memToRegEx = 2'b01;
        #1;
        checks++;
        if (outs() !== c_LDU) begin
            errors++;
            $display("FAIL loaduse_rm: got %b want %b", outs(), c_LDU);
        end
        expStall = expStall + statsOn;
        @(negedge clk);
        setIdle();
        @(negedge clk);
        // Non-load writer to the same register: no stall
        hz.RdEx = 5'd7; hz.RmId = 5'd7; hz.usesRm = 1'b1;
        hz.regWriteEx = 1'b1; hz.memToRegEx = 2'b00;
        #1;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL loaduse_notload: got %b want %b", outs(), c_DEF);
        end
        @(negedge clk);
        setIdle();
    endtask

    task automatic test_xzr();
        @(negedge clk);
        applyLoadRn(5'd31);
        #1;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL xzr_nostall: got %b want %b", outs(), c_DEF);
        end
        @(negedge clk);
        setIdle();
        #1;
        checks++;
        if (hz.stallCount !== 16'(expStall)) begin
            errors++;
            $display("FAIL xzr_stallCount: got %0d want %0d", hz.stallCount, expStall);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        hz.brTakenEx = 1'b1;
        #1;
        checks++;
        if (outs() !== c_BR) begin
            errors++;
            $display("FAIL branch_detect: got %b want %b", outs(), c_BR);
        end
        expFlush = expFlush + statsOn;
        // loadUse present during BRFLUSH must be ignored
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            hz.brTakenEx = 1'b0;
            applyLoadRn(5'd4);
            #1;
            checks++;
            if (outs() !== c_BRF) begin
                errors++;
                $display("FAIL branch_flush%0d: got %b want %b", i, outs(), c_BRF);
            end
        end
        @(negedge clk);
        setIdle();
        #1;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL branch_done: got %b want %b", outs(), c_DEF);
        end
        checks++;
        if (hz.flushCount !== 16'(expFlush)) begin
            errors++;
            $display("FAIL branch_flushCount: got %0d want %0d", hz.flushCount, expFlush);
        end
        checks++;
        if (hz.stallCount !== 16'(expStall)) begin
            errors++;
            $display("FAIL branch_stallCount: got %0d want %0d", hz.stallCount, expStall);
        end
    endtask

    task automatic test_busy_in_flush();
        int flushCycles;
        flushCycles = 0;
        @(negedge clk);
        hz.brTakenEx = 1'b1;
        #1;
        if (hz.ifidFlush === 1'b1) flushCycles++;
        checks++;
        if (outs() !== c_BR) begin
            errors++;
            $display("FAIL busy_branch: got %b want %b", outs(), c_BR);
        end
        expFlush = expFlush + statsOn;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hz.brTakenEx = 1'b0;
            hz.dmemBusy  = 1'b1;
            #1;
            if (hz.ifidFlush === 1'b1) flushCycles++;
            checks++;
            if (outs() !== c_BUSY) begin
                errors++;
                $display("FAIL busy_hold%0d: got %b want %b", i, outs(), c_BUSY);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            hz.dmemBusy = 1'b0;
            #1;
            if (hz.ifidFlush === 1'b1) flushCycles++;
            checks++;
            if (outs() !== c_BRF) begin
                errors++;
                $display("FAIL busy_resume%0d: got %b want %b", i, outs(), c_BRF);
            end
        end
        @(negedge clk);
        #1;
        if (hz.ifidFlush === 1'b1) flushCycles++;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL busy_done: got %b want %b", outs(), c_DEF);
        end
        checks++;
        if (flushCycles != 3) begin
            errors++;
            $display("FAIL busy_flush_total: got %0d want 3", flushCycles);
        end
        checks++;
        if (hz.flushCount !== 16'(expFlush)) begin
            errors++;
            $display("FAIL busy_flushCount: got %0d want %0d", hz.flushCount, expFlush);
        end
    endtask

    task automatic test_branch_vs_loaduse();
        @(negedge clk);
        hz.brTakenEx = 1'b1;
        applyLoadRn(5'd5);
        #1;
        checks++;
        if (outs() !== c_BR) begin
            errors++;
            $display("FAIL brlu_priority: got %b want %b", outs(), c_BR);
        end
        expFlush = expFlush + statsOn;
        @(negedge clk);
        setIdle();
        #1;
        checks++;
        if (hz.stallCount !== 16'(expStall)) begin
            errors++;
            $display("FAIL brlu_stallCount: got %0d want %0d", hz.stallCount, expStall);
        end
        checks++;
        if (hz.flushCount !== 16'(expFlush)) begin
            errors++;
            $display("FAIL brlu_flushCount: got %0d want %0d", hz.flushCount, expFlush);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        applyLoadRn(5'd6);
        #1;
        checks++;
        if (outs() !== c_LDU) begin
            errors++;
            $display("FAIL rst_stall_enter: got %b want %b", outs(), c_LDU);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== c_DEF) begin
            errors++;
            $display("FAIL rst_held_outputs: got %b want %b", outs(), c_DEF);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hz.stallCount !== 16'd0) begin
            errors++;
            $display("FAIL rst_stallCount: got %0d want 0", hz.stallCount);
        end
        checks++;
        if (hz.flushCount !== 16'd0) begin
            errors++;
            $display("FAIL rst_flushCount: got %0d want 0", hz.flushCount);
        end
        // Back in RUN, so the same load-use stalls again instead of being suppressed
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== c_LDU) begin
            errors++;
            $display("FAIL rst_state_run: got %b want %b", outs(), c_LDU);
        end
        @(negedge clk);
        setIdle();
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        errors   = 0;
        checks   = 0;
        expStall = 0;
        expFlush = 0;
`ifdef HAZARD_STATS_EN
        statsOn = 1;
`else
        statsOn = 0;
`endif
        setIdle();
        test_reset();
        test_loaduse();
        test_xzr();
        test_branch();
        test_busy_in_flush();
        test_branch_vs_loaduse();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
